// File: rtl/stack_exec_unit.sv
// Command sequencer for the ClangPU operand stack: runs one stack-machine
// command at a time by strobing the stack's push/pop ports, keeps a depth mirror and a sticky error.
module stack_exec_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [3:0] CMD_OP,
  input  logic [7:0] CMD_IMM,
  output logic       RES_VALID,
  output logic [7:0] RES_DATA,
  output logic       ST_PUSH,
  output logic [7:0] ST_WDATA,
  output logic       ST_POP,
  input  logic       ST_OVALID,
  input  logic [7:0] ST_ODATA,
  input  logic       ST_FULL,
  input  logic       ST_EMPTY,
  output logic [9:0] DEPTH,
  output logic       ERR,
  output logic [1:0] ERR_CODE,
  input  logic       CLR_ERR
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_EQ   = 4'd8;
  localparam logic [3:0] OP_LTU  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;

  localparam logic [1:0] E_UNDER   = 2'd1;
  localparam logic [1:0] E_OVER    = 2'd2;
  localparam logic [1:0] E_ILLEGAL = 2'd3;

  localparam logic [9:0] MAX_DEPTH = 10'd1022;

  typedef enum logic [2:0] {IDLE, POP1, WAIT1, POP2, WAIT2, PUSH} state_t;

  state_t     state, next_state;
  logic [3:0] op_q;
  logic [7:0] b_q;
  logic [7:0] wdata_q;
  logic [7:0] res_data_q;
  logic [9:0] depth_q;
  logic       err_q;
  logic [1:0] err_code_q;
  logic       err_set;
  logic [1:0] err_set_code;

  // A is the deeper operand, B the former top of stack.
  function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a,
                                     input logic [7:0] b);
    logic [7:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_EQ:   r = (a == b) ? 8'h01 : 8'h00;
      OP_LTU:  r = (a < b) ? 8'h01 : 8'h00;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state   = state;
    CMD_READY    = 1'b0;
    ST_PUSH      = 1'b0;
    ST_POP       = 1'b0;
    RES_VALID    = 1'b0;
    err_set      = 1'b0;
    err_set_code = 2'd0;
    case (state)
      IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          if (CMD_OP > OP_NOT) begin
            err_set      = 1'b1;
            err_set_code = E_ILLEGAL;
          end else if (CMD_OP == OP_PUSH) begin
            if (DEPTH == MAX_DEPTH || ST_FULL) begin
              err_set      = 1'b1;
              err_set_code = E_OVER;
            end else begin
              next_state = PUSH;
            end
          end else if (CMD_OP == OP_POP || CMD_OP == OP_NOT) begin
            if (DEPTH == 10'd0 || ST_EMPTY) begin
              err_set      = 1'b1;
              err_set_code = E_UNDER;
            end else begin
              next_state = POP1;
            end
          end else if (CMD_OP != OP_NOP) begin
            if (DEPTH < 10'd2 || ST_EMPTY) begin
              err_set      = 1'b1;
              err_set_code = E_UNDER;
            end else begin
              next_state = POP1;
            end
          end
        end
      end
      POP1: begin
        ST_POP     = 1'b1;
        next_state = WAIT1;
      end
      WAIT1: begin
        RES_VALID = (op_q == OP_POP);
        if (!ST_OVALID) begin
          err_set      = 1'b1;
          err_set_code = E_UNDER;
          next_state   = IDLE;
        end else if (op_q == OP_POP) begin
          next_state = IDLE;
        end else if (op_q == OP_NOT) begin
          next_state = PUSH;
        end else begin
          next_state = POP2;
        end
      end
      POP2: begin
        ST_POP     = 1'b1;
        next_state = WAIT2;
      end
      WAIT2: begin
        if (!ST_OVALID) begin
          err_set      = 1'b1;
          err_set_code = E_UNDER;
          next_state   = IDLE;
        end else begin
          next_state = PUSH;
        end
      end
      PUSH: begin
        ST_PUSH    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand latches, depth mirror and the sticky error; a missing pop-valid
  // means the mirror has drifted from the real stack, so it is resynced to 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q       <= OP_NOP;
      b_q        <= 8'h00;
      wdata_q    <= 8'h00;
      res_data_q <= 8'h00;
      depth_q    <= 10'd0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
    end else begin
      if (state == IDLE && next_state != IDLE) op_q <= CMD_OP;
      if (state == IDLE && next_state == PUSH) wdata_q <= CMD_IMM;
      case (state)
        POP1, POP2: depth_q <= depth_q - 10'd1;
        PUSH:       depth_q <= depth_q + 10'd1;
        WAIT1: begin
          if (!ST_OVALID)            depth_q    <= 10'd0;
          else if (op_q == OP_POP)   res_data_q <= ST_ODATA;
          else if (op_q == OP_NOT)   wdata_q    <= ~ST_ODATA;
          else                       b_q        <= ST_ODATA;
        end
        WAIT2: begin
          if (!ST_OVALID) depth_q <= 10'd0;
          else            wdata_q <= alu(op_q, ST_ODATA, b_q);
        end
        default: ;
      endcase
      if (err_set) begin
        err_q <= 1'b1;
        if (!err_q || CLR_ERR) err_code_q <= err_set_code;
      end else if (CLR_ERR) begin
        err_q      <= 1'b0;
        err_code_q <= 2'd0;
      end
    end
  end

  assign ST_WDATA = wdata_q;
  assign RES_DATA = res_data_q;
  assign DEPTH    = depth_q;
  assign ERR      = err_q;
  assign ERR_CODE = err_code_q;

endmodule

// File: tb/tb_stack_exec_unit.sv
// Directed bench for stack_exec_unit: a behavioural operand stack answers the
// DUT's strobes while a command table and a few hand sequences are checked.
module tb_stack_exec_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [3:0] CMD_OP = 4'd0;
  logic [7:0] CMD_IMM = 8'h00;
  logic       RES_VALID;
  logic [7:0] RES_DATA;
  logic       ST_PUSH;
  logic [7:0] ST_WDATA;
  logic       ST_POP;
  logic       ST_OVALID;
  logic [7:0] ST_ODATA;
  logic       ST_FULL;
  logic       ST_EMPTY;
  logic [9:0] DEPTH;
  logic       ERR;
  logic [1:0] ERR_CODE;
  logic       CLR_ERR = 1'b0;

  localparam logic [3:0] NOP = 4'd0, PSH = 4'd1, POP = 4'd2, ADD = 4'd3, SUB = 4'd4,
                         AND = 4'd5, OR = 4'd6, XOR = 4'd7, EQ = 4'd8, LTU = 4'd9,
                         NOT = 4'd10;

  stack_exec_unit dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_IMM(CMD_IMM), .RES_VALID(RES_VALID), .RES_DATA(RES_DATA),
    .ST_PUSH(ST_PUSH), .ST_WDATA(ST_WDATA), .ST_POP(ST_POP), .ST_OVALID(ST_OVALID),
    .ST_ODATA(ST_ODATA), .ST_FULL(ST_FULL), .ST_EMPTY(ST_EMPTY), .DEPTH(DEPTH),
    .ERR(ERR), .ERR_CODE(ERR_CODE), .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  // Behavioural 1024-entry stack; pop data and valid appear the cycle after ST_POP.
  logic [7:0] mem [0:1023];
  int         sp = 0;
  logic       drop_ovalid = 1'b0;
  assign ST_FULL  = (sp >= 1024);
  assign ST_EMPTY = (sp == 0);

  always @(posedge CLK) begin
    if (RST) begin
      sp        <= 0;
      ST_OVALID <= 1'b0;
      ST_ODATA  <= 8'h00;
    end else begin
      ST_OVALID <= ST_POP && (sp != 0) && !drop_ovalid;
      if (ST_POP && sp != 0) begin
        ST_ODATA <= mem[sp-1];
        sp       <= sp - 1;
      end else if (ST_PUSH && sp < 1024) begin
        mem[sp] <= ST_WDATA;
        sp      <= sp + 1;
      end
    end
  end

  int         push_cnt = 0, pop_cnt = 0, res_cnt = 0, overlap_cnt = 0;
  logic [7:0] last_push = 8'h00;

  always @(negedge CLK) begin
    if (ST_PUSH) begin
      push_cnt++;
      last_push = ST_WDATA;
    end
    if (ST_POP) pop_cnt++;
    if (RES_VALID) res_cnt++;
    if (ST_PUSH && ST_POP) overlap_cnt++;
  end

  int checks = 0;
  int errors = 0;
  int busy_cycles;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issues one command and returns at the first negedge where the unit is ready again.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] imm);
    int n;
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_IMM   = imm;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    n = 0;
    while (!CMD_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    busy_cycles = n;
    if (n >= 20) checkOutput("ready timeout", 0, 1);
  endtask

  task automatic pulseClear();
    @(negedge CLK);
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
  endtask

  task automatic doReset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] imm;
    int         depth;
    int         busy;
    int         res;
    logic [7:0] res_data;
    int         push;
    int         pop;
    logic [7:0] pushed;
    int         err;
    int         code;
  } vec_t;

  vec_t vecs [24];

  initial begin
    int p0, q0, r0;

    //                op   imm   dep busy res rdat  push pop pushed err code
    vecs[0]  = '{PSH, 8'h03, 1, 1, 0, 8'h00, 1, 0, 8'h03, 0, 0};
    vecs[1]  = '{PSH, 8'h05, 2, 1, 0, 8'h00, 1, 0, 8'h05, 0, 0};
    vecs[2]  = '{SUB, 8'h00, 1, 5, 0, 8'h00, 1, 2, 8'hFE, 0, 0};
    vecs[3]  = '{POP, 8'h00, 0, 2, 1, 8'hFE, 0, 1, 8'h00, 0, 0};
    vecs[4]  = '{PSH, 8'hF0, 1, 1, 0, 8'h00, 1, 0, 8'hF0, 0, 0};
    vecs[5]  = '{PSH, 8'h20, 2, 1, 0, 8'h00, 1, 0, 8'h20, 0, 0};
    vecs[6]  = '{ADD, 8'h00, 1, 5, 0, 8'h00, 1, 2, 8'h10, 0, 0};
    vecs[7]  = '{PSH, 8'h10, 2, 1, 0, 8'h00, 1, 0, 8'h10, 0, 0};
    vecs[8]  = '{EQ,  8'h00, 1, 5, 0, 8'h00, 1, 2, 8'h01, 0, 0};
    vecs[9]  = '{NOT, 8'h00, 1, 3, 0, 8'h00, 1, 1, 8'hFE, 0, 0};
    vecs[10] = '{PSH, 8'h07, 2, 1, 0, 8'h00, 1, 0, 8'h07, 0, 0};
    vecs[11] = '{XOR, 8'h00, 1, 5, 0, 8'h00, 1, 2, 8'hF9, 0, 0};
    vecs[12] = '{PSH, 8'h0F, 2, 1, 0, 8'h00, 1, 0, 8'h0F, 0, 0};
    vecs[13] = '{AND, 8'h00, 1, 5, 0, 8'h00, 1, 2, 8'h09, 0, 0};
    vecs[14] = '{PSH, 8'h30, 2, 1, 0, 8'h00, 1, 0, 8'h30, 0, 0};
    vecs[15] = '{OR,  8'h00, 1, 5, 0, 8'h00, 1, 2, 8'h39, 0, 0};
    vecs[16] = '{PSH, 8'h40, 2, 1, 0, 8'h00, 1, 0, 8'h40, 0, 0};
    vecs[17] = '{LTU, 8'h00, 1, 5, 0, 8'h00, 1, 2, 8'h01, 0, 0};
    vecs[18] = '{PSH, 8'h00, 2, 1, 0, 8'h00, 1, 0, 8'h00, 0, 0};
    vecs[19] = '{LTU, 8'h00, 1, 5, 0, 8'h00, 1, 2, 8'h00, 0, 0};
    vecs[20] = '{POP, 8'h00, 0, 2, 1, 8'h00, 0, 1, 8'h00, 0, 0};
    vecs[21] = '{NOP, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    vecs[22] = '{POP, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1};
    vecs[23] = '{ADD, 8'h00, 0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1};

    doReset();
    checkOutput("reset CMD_READY", CMD_READY, 1);
    checkOutput("reset DEPTH", DEPTH, 0);
    checkOutput("reset ERR", ERR, 0);
    checkOutput("reset ST_PUSH/POP/RES_VALID", {ST_PUSH, ST_POP, RES_VALID}, 0);
    checkOutput("reset ST_WDATA", ST_WDATA, 0);

    for (int i = 0; i < 24; i++) begin
      p0 = push_cnt;
      q0 = pop_cnt;
      r0 = res_cnt;
      applyStimulus(vecs[i].op, vecs[i].imm);
      checkOutput($sformatf("v%0d depth", i), DEPTH, vecs[i].depth);
      checkOutput($sformatf("v%0d busy cycles", i), busy_cycles, vecs[i].busy);
      checkOutput($sformatf("v%0d res pulses", i), res_cnt - r0, vecs[i].res);
      checkOutput($sformatf("v%0d push strobes", i), push_cnt - p0, vecs[i].push);
      checkOutput($sformatf("v%0d pop strobes", i), pop_cnt - q0, vecs[i].pop);
      checkOutput($sformatf("v%0d ERR", i), ERR, vecs[i].err);
      checkOutput($sformatf("v%0d ERR_CODE", i), ERR_CODE, vecs[i].code);
      if (vecs[i].push > 0)
        checkOutput($sformatf("v%0d pushed value", i), last_push, vecs[i].pushed);
      if (vecs[i].res > 0)
        checkOutput($sformatf("v%0d RES_DATA", i), RES_DATA, vecs[i].res_data);
    end

    pulseClear();
    checkOutput("clear ERR", ERR, 0);
    checkOutput("clear ERR_CODE", ERR_CODE, 0);
    checkOutput("clear keeps DEPTH", DEPTH, 0);

    // Illegal opcode is the first error; a later underflow must not overwrite its code.
    applyStimulus(4'hC, 8'h00);
    checkOutput("illegal ERR_CODE", ERR_CODE, 3);
    applyStimulus(POP, 8'h00);
    checkOutput("first error held", ERR_CODE, 3);
    checkOutput("first error ERR", ERR, 1);
    pulseClear();

    // Fill to capacity, then the extra PUSH must be rejected without a strobe.
    doReset();
    for (int i = 0; i < 1022; i++) applyStimulus(PSH, i[7:0]);
    checkOutput("full DEPTH", DEPTH, 1022);
    checkOutput("full no error yet", ERR, 0);
    p0 = push_cnt;
    applyStimulus(PSH, 8'hAA);
    checkOutput("overflow ERR_CODE", ERR_CODE, 2);
    checkOutput("overflow DEPTH held", DEPTH, 1022);
    checkOutput("overflow no push", push_cnt - p0, 0);
    checkOutput("overflow busy", busy_cycles, 0);

    // Lost pop-valid: underflow and depth resync to zero.
    doReset();
    applyStimulus(PSH, 8'h55);
    applyStimulus(PSH, 8'h66);
    drop_ovalid = 1'b1;
    p0 = push_cnt;
    applyStimulus(ADD, 8'h00);
    drop_ovalid = 1'b0;
    checkOutput("lost ovalid ERR_CODE", ERR_CODE, 1);
    checkOutput("lost ovalid DEPTH", DEPTH, 0);
    checkOutput("lost ovalid no push", push_cnt - p0, 0);

    // Reset in the middle of popping an LTU result.
    doReset();
    applyStimulus(PSH, 8'h07);
    applyStimulus(PSH, 8'h09);
    applyStimulus(LTU, 8'h00);
    checkOutput("ltu pushed", last_push, 8'h01);
    checkOutput("ltu DEPTH", DEPTH, 1);
    @(negedge CLK);
    CMD_VALID = 1'b1;
    CMD_OP    = POP;
    @(negedge CLK);
    CMD_VALID = 1'b0;
    checkOutput("mid-pop ST_POP", ST_POP, 1);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("mid-reset CMD_READY", CMD_READY, 1);
    checkOutput("mid-reset strobes", {ST_PUSH, ST_POP, RES_VALID}, 0);
    checkOutput("mid-reset ST_WDATA", ST_WDATA, 0);
    checkOutput("mid-reset RES_DATA", RES_DATA, 0);
    checkOutput("mid-reset DEPTH", DEPTH, 0);
    checkOutput("mid-reset ERR", {ERR, ERR_CODE}, 0);
    RST = 1'b0;
    @(negedge CLK);

    checkOutput("push/pop overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
